// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and default operand width for the multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH_DEFAULT = 32;

   // Op codes are shared with the ALU decode
   localparam logic [3:0] OP_MULT  = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIV   = 4'b1110;
   localparam logic [3:0] OP_DIVU  = 4'b1111;
   localparam logic [3:0] OP_MADD  = 4'b1000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP
   } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bus between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_if #(
   parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
) ();

   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wr_data,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wr_data,
      output busy, done, hi, lo, div_by_zero
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift-right for multiply, restoring subtract-shift-left for divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               in_bit,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] rem_sub;
   logic             ge;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
      shifted  = {acc[2*WIDTH-1:WIDTH], in_bit};
      ge       = shifted >= {1'b0, operand};
      // When ge holds the true difference is below 2^WIDTH, so the truncated subtract is exact
      rem_sub  = shifted[WIDTH-1:0] - operand;
      q_bit    = is_div & ge;
      acc_next = {sum, acc[WIDTH-1:1]};
      if (is_div) begin
         acc_next = {(ge ? rem_sub : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers; fixed WIDTH+2 cycle latency.
// Define MULDIV_MADD_EN to enable op 1000 (MADD: {hi,lo} += signed a * signed b).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = 6
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2*WIDTH-1:0] acc_reg, acc_step;
   logic [WIDTH-1:0]   operand_reg, shift_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               is_div_reg, neg_lo_reg, neg_hi_reg, dz_reg;
   logic               done_reg, dz_out_reg;
`ifdef MULDIV_MADD_EN
   logic               is_madd_reg;
`endif

   logic               op_legal, is_signed, is_div_op, start_ok, last_iter, q_bit, in_bit;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

   always_comb begin
      op_legal  = 1'b0;
      is_signed = 1'b0;
      case (bus.op)
         OP_MULT, OP_DIV: begin
            op_legal  = 1'b1;
            is_signed = 1'b1;
         end
         OP_MULTU, OP_DIVU: op_legal = 1'b1;
`ifdef MULDIV_MADD_EN
         OP_MADD: begin
            op_legal  = 1'b1;
            is_signed = 1'b1;
         end
`endif
         default: ;
      endcase
      is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      a_neg     = is_signed & bus.a[WIDTH-1];
      b_neg     = is_signed & bus.b[WIDTH-1];
      a_mag     = a_neg ? -bus.a : bus.a;
      b_mag     = b_neg ? -bus.b : bus.b;
      start_ok  = (state_reg == IDLE) && bus.start && op_legal;
      last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
      in_bit    = is_div_reg ? shift_reg[WIDTH-1] : shift_reg[0];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_ok) state_next = CALC;
         CALC:    if (last_iter) state_next = FIXUP;
         FIXUP:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc_reg),
      .operand  (operand_reg),
      .in_bit   (in_bit),
      .is_div   (is_div_reg),
      .acc_next (acc_step),
      .q_bit    (q_bit)
   );

   // Magnitude result -> signed result; divide-by-zero leaves remainder = |a| which re-signs to a
   always_comb begin
      prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
`ifdef MULDIV_MADD_EN
      if (is_madd_reg) prod_fix = prod_fix + {hi_reg, lo_reg};
`endif
      quo    = acc_reg[WIDTH-1:0];
      rem    = acc_reg[2*WIDTH-1:WIDTH];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      if (is_div_reg) begin
         fix_lo = dz_reg ? '1 : (neg_lo_reg ? -quo : quo);
         fix_hi = neg_hi_reg ? -rem : rem;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         acc_reg     <= '0;
         operand_reg <= '0;
         shift_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         is_div_reg  <= 1'b0;
         neg_lo_reg  <= 1'b0;
         neg_hi_reg  <= 1'b0;
         dz_reg      <= 1'b0;
         done_reg    <= 1'b0;
         dz_out_reg  <= 1'b0;
`ifdef MULDIV_MADD_EN
         is_madd_reg <= 1'b0;
`endif
      end else begin
         done_reg   <= 1'b0;
         dz_out_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_ok) begin
                  acc_reg     <= '0;
                  cnt_reg     <= '0;
                  is_div_reg  <= is_div_op;
                  neg_lo_reg  <= a_neg ^ b_neg;
                  neg_hi_reg  <= is_div_op & a_neg;
                  dz_reg      <= is_div_op && (bus.b == '0);
                  operand_reg <= is_div_op ? b_mag : a_mag;
                  shift_reg   <= is_div_op ? a_mag : b_mag;
`ifdef MULDIV_MADD_EN
                  is_madd_reg <= (bus.op == OP_MADD);
`endif
               end else begin
                  if (bus.wr_hi) hi_reg <= bus.wr_data;
                  if (bus.wr_lo) lo_reg <= bus.wr_data;
               end
            end
            CALC: begin
               acc_reg   <= {acc_step[2*WIDTH-1:1], acc_step[0] | q_bit};
               cnt_reg   <= cnt_reg + 1'b1;
               shift_reg <= is_div_reg ? (shift_reg << 1) : (shift_reg >> 1);
            end
            FIXUP: begin
               hi_reg     <= fix_hi;
               lo_reg     <= fix_lo;
               done_reg   <= 1'b1;
               dz_out_reg <= dz_reg;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = done_reg;
   assign bus.hi          = hi_reg;
   assign bus.lo          = lo_reg;
   assign bus.div_by_zero = dz_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus hand sequences for reset, writes and busy handshakes.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(32)) mi ();

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mi)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mi.start   = 1'b0;
      mi.wr_hi   = 1'b0;
      mi.wr_lo   = 1'b0;
   endtask

   // intf_cycle>0: drive start+wr_hi in that busy cycle; wr_with_start: wr_lo alongside start
   task automatic run_op(input vec_t v, input int intf_cycle, input bit wr_with_start);
      int done_cycle = -1;
      int busy_cnt   = 0;
      @(negedge clk);
      mi.start = 1'b1;
      mi.op    = v.op;
      mi.a     = v.a;
      mi.b     = v.b;
      if (wr_with_start) begin
         mi.wr_lo   = 1'b1;
         mi.wr_data = 32'h7777_7777;
      end
      @(negedge clk);
      idle_inputs();
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == 1 && wr_with_start) check({v.name, " lo_start_wins"}, 64'(mi.lo), 64'(m_lo));
         if (intf_cycle > 0 && cyc == intf_cycle + 1)
            check({v.name, " hi_hold_busy"}, 64'(mi.hi), 64'(m_hi));
         if (mi.done === 1'b1) begin
            done_cycle = cyc;
            break;
         end
         if (mi.busy === 1'b1) busy_cnt++;
         if (cyc == intf_cycle) begin
            mi.start   = 1'b1;
            mi.op      = OP_DIVU;
            mi.wr_hi   = 1'b1;
            mi.wr_data = 32'hDEAD_BEEF;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
      end
      idle_inputs();
      check({v.name, " done_cycle"}, 64'(done_cycle), 64'd34);
      check({v.name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
      check({v.name, " busy_at_done"}, 64'(mi.busy), 64'd0);
      check({v.name, " hi"}, 64'(mi.hi), 64'(v.hi));
      check({v.name, " lo"}, 64'(mi.lo), 64'(v.lo));
      check({v.name, " dz"}, 64'(mi.div_by_zero), 64'(v.dz));
      $display("op %b a=%h b=%h -> hi=%h lo=%h dz=%b done@%0d (%s)",
               v.op, v.a, v.b, mi.hi, mi.lo, mi.div_by_zero, done_cycle, v.name);
      m_hi = v.hi;
      m_lo = v.lo;
      @(negedge clk);
      check({v.name, " done_pulse"}, 64'(mi.done), 64'd0);
      check({v.name, " dz_pulse"}, 64'(mi.div_by_zero), 64'd0);
      check({v.name, " busy_after"}, 64'(mi.busy), 64'd0);
   endtask

   task automatic idle_write(input bit h, input bit l, input logic [31:0] data);
      @(negedge clk);
      mi.wr_hi   = h;
      mi.wr_lo   = l;
      mi.wr_data = data;
      @(negedge clk);
      idle_inputs();
      if (h) m_hi = data;
      if (l) m_lo = data;
      check("idle_write hi", 64'(mi.hi), 64'(m_hi));
      check("idle_write lo", 64'(mi.lo), 64'(m_lo));
      $display("write hi=%b lo=%b data=%h -> hi=%h lo=%h", h, l, data, mi.hi, mi.lo);
   endtask

   task automatic illegal_start(input logic [3:0] op);
      int bad = 0;
      @(negedge clk);
      mi.start = 1'b1;
      mi.op    = op;
      mi.a     = 32'h1111_1111;
      mi.b     = 32'h2222_2222;
      @(negedge clk);
      idle_inputs();
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (mi.busy !== 1'b0 || mi.done !== 1'b0) bad++;
         @(negedge clk);
      end
      check("illegal_op activity", 64'(bad), 64'd0);
      check("illegal_op hi", 64'(mi.hi), 64'(m_hi));
      check("illegal_op lo", 64'(mi.lo), 64'(m_lo));
      $display("illegal op %b -> busy/done cycles=%0d", op, bad);
   endtask

   vec_t vecs[13];
   vec_t extra;

   initial begin
      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7"};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7_2"};
      vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_overflow"};
      vecs[4]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, "divu_by_zero"};
      vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_by_zero"};
      vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7"};
      vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, "multu_shift"};
      vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minsq"};
      vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7_neg2"};
      vecs[10] = '{OP_MULT,  32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0, "mult_5_neg4"};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, "divu_max_16"};
      vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, "div_neg8_neg3"};

      rst        = 1'b1;
      mi.start   = 1'b0;
      mi.op      = 4'b0000;
      mi.a       = '0;
      mi.b       = '0;
      mi.wr_hi   = 1'b0;
      mi.wr_lo   = 1'b0;
      mi.wr_data = '0;
      m_hi       = '0;
      m_lo       = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset busy", 64'(mi.busy), 64'd0);
      check("reset done", 64'(mi.done), 64'd0);
      check("reset hi", 64'(mi.hi), 64'd0);
      check("reset lo", 64'(mi.lo), 64'd0);
      check("reset dz", 64'(mi.div_by_zero), 64'd0);

      for (int i = 0; i < 13; i++) run_op(vecs[i], 0, 1'b0);

      // Idle MTHI/MTLO writes, alone and together
      idle_write(1'b0, 1'b1, 32'h0000_1234);
      idle_write(1'b1, 1'b0, 32'h0000_ABCD);
      idle_write(1'b1, 1'b1, 32'h5555_AAAA);

      // start and wr_hi while busy are ignored; hi holds until FIXUP
      extra = '{OP_MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0, "busy_ignore"};
      run_op(extra, 5, 1'b0);

      // start with wr_lo in the same idle cycle: start wins
      idle_write(1'b0, 1'b1, 32'h0BAD_0BAD);
      extra = '{OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, "start_wins"};
      run_op(extra, 0, 1'b1);

      // Reset in the middle of a MULT discards the result
      begin
         int dones = 0;
         @(negedge clk);
         mi.start = 1'b1;
         mi.op    = OP_MULT;
         mi.a     = 32'h0000_1000;
         mi.b     = 32'h0000_0300;
         @(negedge clk);
         idle_inputs();
         repeat (9) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst  = 1'b0;
         m_hi = '0;
         m_lo = '0;
         check("midop_rst busy", 64'(mi.busy), 64'd0);
         check("midop_rst hi", 64'(mi.hi), 64'd0);
         check("midop_rst lo", 64'(mi.lo), 64'd0);
         for (int cyc = 0; cyc < 40; cyc++) begin
            if (mi.done === 1'b1) dones++;
            @(negedge clk);
         end
         check("midop_rst no_done", 64'(dones), 64'd0);
         $display("reset mid-MULT -> busy=%b hi=%h lo=%h dones=%0d", mi.busy, mi.hi, mi.lo, dones);
      end
      extra = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "after_reset"};
      run_op(extra, 0, 1'b0);

      illegal_start(4'b0101);
`ifdef MULDIV_MADD_EN
      idle_write(1'b1, 1'b1, 32'h0000_0000);
      idle_write(1'b0, 1'b1, 32'h0000_000A);
      extra = '{OP_MADD, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF5, 1'b0, "madd"};
      run_op(extra, 0, 1'b0);
`else
      illegal_start(4'b1000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
